// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing control beside decode: forwarding selects,
// load-use and mult/div stalls, IF/ID flush and a stall counter.
module pipe_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [4:0]       drs,
    input  logic [4:0]       drt,
    input  logic             duse_rs,
    input  logic             duse_rt,
    input  logic [4:0]       ern,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic             dbranch_taken,
    input  logic             dmd_start,
    input  logic             mdu_done,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             dbubble,
    output logic             iflush,
    output logic             mdu_go,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(MD_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t          state;
    state_t          nstate;
    logic [WC_W-1:0] wcnt;
    logic            wc_clr;
    logic            wc_inc;
    logic            tmo_set;
    logic            lu;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] e_rn,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] m_rn,
        input logic       m_wreg,
        input logic       m_m2reg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (e_wreg && !e_m2reg && e_rn != 5'd0 && e_rn == src) begin
            sel = 2'b01;
        end else if (m_wreg && m_rn != 5'd0 && m_rn == src) begin
            sel = m_m2reg ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    assign fwda = fwd_sel(drs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
    assign fwdb = fwd_sel(drt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);

    assign lu = ewreg && em2reg && ern != 5'd0 &&
                ((duse_rs && drs == ern) || (duse_rt && drt == ern));

    always_comb begin
        nstate  = state;
        wpcir   = 1'b1;
        dbubble = 1'b0;
        mdu_go  = 1'b0;
        wc_clr  = 1'b0;
        wc_inc  = 1'b0;
        tmo_set = 1'b0;
        unique case (state)
            RUN: begin
                // A pending load-use takes precedence; the MDU launch waits a cycle.
                if (lu) begin
                    wpcir   = 1'b0;
                    dbubble = 1'b1;
                end else if (dmd_start) begin
                    mdu_go  = 1'b1;
                    wpcir   = 1'b0;
                    dbubble = 1'b1;
                    wc_clr  = 1'b1;
                    nstate  = MD_WAIT;
                end
            end
            MD_WAIT: begin
                if (mdu_done) begin
                    nstate = RUN;
                end else if (wcnt == WC_LAST) begin
                    tmo_set = 1'b1;
                    nstate  = RUN;
                end else begin
                    wpcir   = 1'b0;
                    dbubble = 1'b1;
                    wc_inc  = 1'b1;
                end
            end
            default: nstate = RUN;
        endcase
    end

    assign iflush = dbranch_taken & wpcir;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= RUN;
            wcnt       <= '0;
            md_timeout <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state <= nstate;
            if (wc_clr) begin
                wcnt <= '0;
            end else if (wc_inc) begin
                wcnt <= wcnt + 1'b1;
            end
            if (tmo_set) begin
                md_timeout <= 1'b1;
            end
            if (!wpcir && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle reference model
// and hand-computed spot checks.
module tb_pipe_hazard_ctrl;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  drs, drt, ern, mrn;
    logic        duse_rs, duse_rt, ewreg, em2reg, mwreg, mm2reg;
    logic        dbranch_taken, dmd_start, mdu_done;
    logic [1:0]  fwda, fwdb;
    logic        wpcir, dbubble, iflush, mdu_go, md_timeout;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: MDU busy flag, cycles spent waiting, timeout flag, stalls
    bit     m_wait = 0;
    int     m_cyc  = 0;
    bit     m_tmo  = 0;
    longint m_stl  = 0;
    bit     n_wait = 0;
    int     n_cyc  = 0;
    bit     n_tmo  = 0;
    longint n_stl  = 0;

    pipe_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(32)) dut (
        .clock(clock), .resetn(resetn),
        .drs(drs), .drt(drt), .duse_rs(duse_rs), .duse_rt(duse_rt),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .dbranch_taken(dbranch_taken), .dmd_start(dmd_start),
        .mdu_done(mdu_done),
        .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .dbubble(dbubble),
        .iflush(iflush), .mdu_go(mdu_go), .md_timeout(md_timeout),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input int src);
        if (src != 0 && ewreg && !em2reg && int'(ern) == src) return 1;
        if (src != 0 && mwreg && int'(mrn) == src) return mm2reg ? 3 : 2;
        return 0;
    endfunction

    always @(negedge clock) begin
        bit lu_h;
        bit hold;
        bit go;
        bit fin;
        lu_h = ewreg && em2reg && ern != 0 &&
               ((duse_rs && drs == ern) || (duse_rt && drt == ern));
        fin  = m_wait && (mdu_done || m_cyc == TO - 1);
        go   = !m_wait && !lu_h && dmd_start;
        hold = m_wait ? !fin : (lu_h || dmd_start);
        chk("fwda", 32'(fwda), 32'(ref_fwd(int'(drs))));
        chk("fwdb", 32'(fwdb), 32'(ref_fwd(int'(drt))));
        chk("wpcir", 32'(wpcir), 32'(!hold));
        chk("dbubble", 32'(dbubble), 32'(hold));
        chk("iflush", 32'(iflush), 32'(dbranch_taken && !hold));
        chk("mdu_go", 32'(mdu_go), 32'(go));
        chk("md_timeout", 32'(md_timeout), 32'(m_tmo));
        chk("stall_cnt", stall_cnt, m_stl[31:0]);
        n_wait = go ? 1'b1 : (m_wait && !fin);
        n_cyc  = go ? 0 : (m_wait && !fin ? m_cyc + 1 : m_cyc);
        n_tmo  = m_tmo || (m_wait && !mdu_done && m_cyc == TO - 1);
        n_stl  = (hold && m_stl < 64'hFFFF_FFFF) ? m_stl + 1 : m_stl;
    end

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_wait <= 0;
            m_cyc  <= 0;
            m_tmo  <= 0;
            m_stl  <= 0;
        end else begin
            m_wait <= n_wait;
            m_cyc  <= n_cyc;
            m_tmo  <= n_tmo;
            m_stl  <= n_stl;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        drs = 0; drt = 0; duse_rs = 0; duse_rt = 0;
        ern = 0; ewreg = 0; em2reg = 0;
        mrn = 0; mwreg = 0; mm2reg = 0;
        dbranch_taken = 0; dmd_start = 0; mdu_done = 0;
    endtask

    initial begin
        resetn = 0;
        clr();
        #3;
        chk("rst_wpcir", 32'(wpcir), 32'd1);
        chk("rst_dbubble", 32'(dbubble), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_md_timeout", 32'(md_timeout), 32'd0);
        chk("rst_fwda", 32'(fwda), 32'd0);
        repeat (2) @(posedge clock);
        #1 resetn = 1;
        step();

        ewreg = 1; ern = 5; em2reg = 0; mwreg = 1; mrn = 5; mm2reg = 1;
        drs = 5;
        #2 chk("fwd_ex_prio", 32'(fwda), 32'd1);
        step();
        ewreg = 0;
        #2 chk("fwd_mem_load", 32'(fwda), 32'd3);
        step();
        drs = 0; ern = 0; mrn = 0; ewreg = 1;
        #2 chk("fwd_r0", 32'(fwda), 32'd0);
        step();
        clr();
        mwreg = 1; mrn = 5; drt = 5;
        #2 chk("fwdb_mem_alu", 32'(fwdb), 32'd2);
        step();

        clr();
        ewreg = 1; em2reg = 1; ern = 8; drt = 8; duse_rt = 1;
        #2 chk("lu_wpcir", 32'(wpcir), 32'd0);
        chk("lu_dbubble", 32'(dbubble), 32'd1);
        step();
        ewreg = 0; em2reg = 0; ern = 0; mwreg = 1; mm2reg = 1; mrn = 8;
        #2 chk("lu_after_fwdb", 32'(fwdb), 32'd3);
        chk("lu_after_wpcir", 32'(wpcir), 32'd1);
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        step();
        clr();
        ewreg = 1; em2reg = 1; ern = 8; drt = 8; duse_rt = 0;
        #2 chk("lu_unused_rt", 32'(wpcir), 32'd1);
        step();

        duse_rt = 1; dbranch_taken = 1;
        #2 chk("br_held", 32'(iflush), 32'd0);
        step();
        ewreg = 0; em2reg = 0;
        #2 chk("br_flush", 32'(iflush), 32'd1);
        chk("br_stall_cnt", stall_cnt, 32'd2);
        step();

        clr();
        dmd_start = 1;
        #2 chk("md_go", 32'(mdu_go), 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            #2 chk("md_hold_go", 32'(mdu_go), 32'd0);
            chk("md_hold_wpcir", 32'(wpcir), 32'd0);
            step();
        end
        mdu_done = 1;
        #2 chk("md_done_wpcir", 32'(wpcir), 32'd1);
        step();
        clr();
        #2 chk("md_stall_cnt", stall_cnt, 32'd7);
        mdu_done = 1;
        #1 chk("md_done_run", 32'(wpcir), 32'd1);
        step();

        clr();
        dmd_start = 1;
        step();
        for (int i = 0; i < TO - 1; i++) step();
        #2 chk("tmo_release", 32'(wpcir), 32'd1);
        chk("tmo_not_yet", 32'(md_timeout), 32'd0);
        step();
        clr();
        #2 chk("tmo_set", 32'(md_timeout), 32'd1);
        chk("tmo_stall_cnt", stall_cnt, 32'd15);
        repeat (3) step();
        chk("tmo_sticky", 32'(md_timeout), 32'd1);

        dmd_start = 1;
        step();
        step();
        step();
        dmd_start = 0;
        resetn = 0;
        #1 chk("rmd_wpcir", 32'(wpcir), 32'd1);
        chk("rmd_stall_cnt", stall_cnt, 32'd0);
        chk("rmd_md_timeout", 32'(md_timeout), 32'd0);
        step();
        resetn = 1;
        step();
        mdu_done = 1;
        #2 chk("rmd_done_go", 32'(mdu_go), 32'd0);
        chk("rmd_done_bubble", 32'(dbubble), 32'd0);
        step();
        clr();
        step();
        chk("rmd_done_cnt", stall_cnt, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
